mux4b_rr_arbiter: RTL
=====================

// Module: mux4b_rr_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one WIDTH-bit 4:1 mux output among 4 requesters.
//  Grants one requester per tenure, drives the 2-bit mux select and steers its data downstream.
//  Handshake is valid/ready; tenure length is bounded by MAX_HOLD beats when others wait.
// PARAMETERS
//  WIDTH     4  data width per requester and of out_data
//  MAX_HOLD  4  transfer beats an owner may hold before forced rotation (>=1)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        reset, asynchronous assert, active-low
//  req        in   4        req[i]=1: requester i has a beat on d_i
//  d0..d3     in   WIDTH    requester data, stable while req[i]=1
//  ready      in   1        downstream accepts out_data this cycle
//  grant      out  4        one-hot owner (registered), 0000 when idle
//  sel        out  2        mux select = owner index (registered); sel[1]=select1, sel[0]=select0
//  out_valid  out  1        |(grant & req), combinational
//  out_data   out  WIDTH    d[sel] when out_valid, else 0
//  beat       out  1        out_valid & ready: transfer occurs this cycle
// BEHAVIOUR
//  Reset (async, rst_n=0): grant=0000, sel=00, out_valid=0, out_data=0, beat=0;
//   state=IDLE, ptr=3 (port 0 highest priority first), cnt=0. Takes effect immediately, mid-tenure too.
//  States: IDLE (no owner), BUSY (one owner, grant one-hot).
//  Round-robin pick: first set req[i] searching from ptr+1 upward mod 4; ptr <= winner on grant.
//  IDLE -> BUSY at edge where req!=0; grant/sel valid the following cycle (1-cycle latency).
//  BUSY, each edge, in priority order:
//   1. req[owner]=0 (release): pick among current req; any -> new owner same edge, cnt=0;
//      none -> IDLE. No idle bubble between tenures.
//   2. beat=1 and cnt==MAX_HOLD-1: if any req[j], j!=owner -> pick among others, cnt=0;
//      else keep owner, cnt=0.
//   3. beat=1 otherwise: cnt <= cnt+1.
//   4. ready=0: hold grant, sel, cnt unchanged (stall does not consume tenure).
//  cnt width ceil(log2(MAX_HOLD+1)); never exceeds MAX_HOLD-1.
//  Requester dropping req: out_valid falls same cycle (combinational); grant clears next edge.
//  Simultaneous release + new reqs: new owner is RR winner after old owner (ptr), same edge.
//  A requester may re-request after release; it competes normally via ptr.
//  grant and sel always consistent: grant=0001<<sel in BUSY; sel holds last value in IDLE.
//  No combinational path from ready to grant/sel; ready affects only beat and next-state.
// STRUCTURE
//  Package mux4b_arb_pkg: N_PORTS=4, SEL_W=2, state enum {ST_IDLE, ST_BUSY}.
//  Sub-module rr_pick (combinational): inputs req[3:0], ptr[1:0], excl_en, excl[1:0];
//   outputs any, idx[1:0]. Used for both normal and forced-rotation picks.
//  Output steering is an inline case on sel; FSM, ptr, cnt in the top.
// TESTING
//  1 Reset: rst_n=0 with req=1111 -> grant=0000, sel=00, out_valid=0, out_data=0.
//  2 Single: req=0100, d2=4'hA, ready=1 for 3 beats then req=0 -> grant=0100 one cycle
//    after req, sel=10, out_data=A for 3 beats, then grant=0000.
//  3 Rotation: req=1111, ready=1, MAX_HOLD=4 -> grant 0001,0010,0100,1000,0001, each 4 beats, no gaps.
//  4 Stall: owner 1, ready=0 for 5 cycles mid-tenure -> grant=0010 held, beat=0, cnt frozen;
//    after ready=1 remaining beats complete before rotation.
//  5 Release race: owner 0 drops req same cycle req=1010 -> next grant=0010 (RR after 0), not 1000.
//  6 Async reset mid-tenure: owner 2, rst_n low between edges -> grant=0000 immediately;
//    after release with req=1111 -> first grant=0001.

Source files
------------

// File: rtl/mux4b_arb_pkg.sv
// Shared constants, FSM state type and one-hot helper for the 4-port round-robin mux arbiter.
package mux4b_arb_pkg;

   localparam int unsigned N_PORTS = 4;
   localparam int unsigned SEL_W   = 2;

   typedef enum logic {
      ST_IDLE,
      ST_BUSY
   } state_t;

   function automatic logic [N_PORTS-1:0] onehot(input logic [SEL_W-1:0] idx);
      logic [N_PORTS-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/mux4b_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after ptr (mod 4), optionally skipping one port.
module rr_pick
   import mux4b_arb_pkg::*;
(
   input  logic [N_PORTS-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   input  logic               excl_en,
   input  logic [SEL_W-1:0]   excl,
   output logic               any,
   output logic [SEL_W-1:0]   idx
);

   logic [SEL_W-1:0] cand;

   // Scan from farthest to nearest so the nearest hit after ptr is the one left standing.
   always_comb begin
      any  = 1'b0;
      idx  = '0;
      cand = '0;
      for (int unsigned k = N_PORTS; k >= 1; k--) begin
         cand = ptr + SEL_W'(k);
         if (req[cand] && !(excl_en && (cand == excl))) begin
            any = 1'b1;
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/mux4b_rr_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit 4:1 mux among 4 valid/ready requesters.
module mux4b_rr_arbiter
   import mux4b_arb_pkg::*;
#(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_PORTS-1:0] req,
   input  logic [WIDTH-1:0]   d0,
   input  logic [WIDTH-1:0]   d1,
   input  logic [WIDTH-1:0]   d2,
   input  logic [WIDTH-1:0]   d3,
   input  logic               ready,
   output logic [N_PORTS-1:0] grant,
   output logic [SEL_W-1:0]   sel,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic               beat
);

   localparam int unsigned    CNT_W = $clog2(MAX_HOLD + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_HOLD - 1);

   state_t             state, state_n;
   logic [N_PORTS-1:0] grant_n;
   logic [SEL_W-1:0]   sel_n;
   logic [SEL_W-1:0]   ptr, ptr_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic               pick_any;
   logic [SEL_W-1:0]   pick_idx;

   // Excluding the owner while busy is harmless on release (its req is already low),
   // so one picker serves both the release and the forced-rotation decision.
   rr_pick u_pick (
      .req     (req),
      .ptr     (ptr),
      .excl_en (state == ST_BUSY),
      .excl    (sel),
      .any     (pick_any),
      .idx     (pick_idx)
   );

   assign out_valid = |(grant & req);
   assign beat      = out_valid & ready;

   always_comb begin
      out_data = '0;
      if (out_valid) begin
         case (sel)
            2'd0: out_data = d0;
            2'd1: out_data = d1;
            2'd2: out_data = d2;
            2'd3: out_data = d3;
         endcase
      end
   end

   always_comb begin
      state_n = state;
      grant_n = grant;
      sel_n   = sel;
      ptr_n   = ptr;
      cnt_n   = cnt;
      case (state)
         ST_IDLE: begin
            if (pick_any) begin
               state_n = ST_BUSY;
               grant_n = onehot(pick_idx);
               sel_n   = pick_idx;
               ptr_n   = pick_idx;
               cnt_n   = '0;
            end
         end
         ST_BUSY: begin
            if (!req[sel]) begin
               cnt_n = '0;
               if (pick_any) begin
                  grant_n = onehot(pick_idx);
                  sel_n   = pick_idx;
                  ptr_n   = pick_idx;
               end else begin
                  state_n = ST_IDLE;
                  grant_n = '0;
               end
            end else if (beat) begin
               if (cnt == LAST) begin
                  cnt_n = '0;
                  if (pick_any) begin
                     grant_n = onehot(pick_idx);
                     sel_n   = pick_idx;
                     ptr_n   = pick_idx;
                  end
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end
         default: begin
            state_n = ST_IDLE;
            grant_n = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         grant <= '0;
         sel   <= '0;
         ptr   <= 2'd3;
         cnt   <= '0;
      end else begin
         state <= state_n;
         grant <= grant_n;
         sel   <= sel_n;
         ptr   <= ptr_n;
         cnt   <= cnt_n;
      end
   end

endmodule
